// File: rtl/serial_mod_detector_if.sv
// Serial bit-stream bus for serial_mod_detector: input bit stream plus
// registered divisibility flag, remainder and bit count.
interface serial_mod_detector_if #(
  parameter int RW    = 2,
  parameter int CNT_W = 8
);
  // in_valid qualifies a for one cycle; there is no ready, every valid bit is consumed.
  logic             clear;
  logic             lsb_first;
  logic             in_valid;
  logic             a;
  logic             y;
  logic [RW-1:0]    rem;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output clear, lsb_first, in_valid, a,
    input  y, rem, bit_cnt
  );

  modport slave (
    input  clear, lsb_first, in_valid, a,
    output y, rem, bit_cnt
  );
endinterface

// File: rtl/serial_mod_detector.sv
// Serial divisibility detector: tracks value mod MOD one bit per valid cycle,
// MSB-first or LSB-first, with a saturating bit counter.
module serial_mod_detector #(
  parameter int MOD   = 4,
  parameter int RW    = $clog2(MOD),
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_mod_detector_if.slave bus
);

  localparam logic [RW:0] MOD_W = (RW+1)'(MOD);

  logic [RW-1:0]    rem_q, rem_d;
  logic [RW-1:0]    pw_q, pw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             y_q, y_d;
  logic             order_q, order_d;

  logic [RW-1:0]    rem_base, pw_base;
  logic [CNT_W-1:0] cnt_base;
  logic             order_base;
  logic [RW:0]      t_msb, t_lsb, t_pw;

  // Operands are below 2*MOD, so one conditional subtract reduces exactly.
  function automatic logic [RW-1:0] sub_mod(input logic [RW:0] t);
    if (t >= MOD_W) return RW'(t - MOD_W);
    else            return RW'(t);
  endfunction

  always_comb begin
    rem_d      = rem_q;
    pw_d       = pw_q;
    cnt_d      = cnt_q;
    y_d        = y_q;
    order_d    = order_q;
    rem_base   = rem_q;
    pw_base    = pw_q;
    cnt_base   = cnt_q;
    order_base = order_q;

    if (bus.clear) begin
      rem_base   = '0;
      pw_base    = RW'(1);
      cnt_base   = '0;
      order_base = bus.lsb_first;
      rem_d      = '0;
      pw_d       = RW'(1);
      cnt_d      = '0;
      y_d        = 1'b0;
      order_d    = bus.lsb_first;
    end

    t_msb = {rem_base, bus.a};
    t_lsb = {1'b0, rem_base} + (bus.a ? {1'b0, pw_base} : '0);
    t_pw  = {pw_base, 1'b0};

    if (bus.in_valid) begin
      if (order_base) begin
        rem_d = sub_mod(t_lsb);
        pw_d  = sub_mod(t_pw);
      end else begin
        rem_d = sub_mod(t_msb);
      end
      cnt_d = (cnt_base == '1) ? cnt_base : cnt_base + CNT_W'(1);
      y_d   = (rem_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rem_q   <= '0;
      pw_q    <= RW'(1);
      cnt_q   <= '0;
      y_q     <= 1'b0;
      order_q <= bus.lsb_first;
    end else begin
      rem_q   <= rem_d;
      pw_q    <= pw_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      order_q <= order_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.rem     = rem_q;
  assign bus.bit_cnt = cnt_q;

endmodule
